// File: rtl/test_pattern_gen.sv
// -----------------------------------------------------------------------------
// test_pattern_gen
//
// Video test-pattern generator. Tracks the raster position from the de/vsync
// strobes and produces one registered RGB pixel per active-video cycle.
//
// Ports:
//   pixclk     in   pixel clock, all logic on the rising edge
//   reset      in   synchronous, active-high reset
//   de         in   active-video pixel strobe
//   vsync      in   one-cycle frame-start pulse
//   mode       in   [2:0] pattern select, captured only on vsync
//   solid_rgb  in   [23:0] solid colour {R,G,B} for mode 0
//   red        out  [7:0] registered pixel colour, one cycle after de
//   green      out  [7:0]
//   blue       out  [7:0]
//   frame_cnt  out  [7:0] frames started since reset, wraps at 255
//
// Patterns: 0 solid, 1 colour bars, 2 horizontal bands, 3 checkerboard,
//           4 horizontal grey ramp, 5 scrolling checkerboard, 6/7 black.
// -----------------------------------------------------------------------------
module test_pattern_gen #(
    parameter int H_PIXEL    = 1280,
    parameter int V_PIXEL    = 720,
    parameter int NUM_BARS   = 8,
    parameter int NUM_BANDS  = 5,
    parameter int CHECK_LOG2 = 5,
    parameter int CW         = 12
) (
    input  logic        pixclk,
    input  logic        reset,
    input  logic        de,
    input  logic        vsync,
    input  logic [2:0]  mode,
    input  logic [23:0] solid_rgb,
    output logic [7:0]  red,
    output logic [7:0]  green,
    output logic [7:0]  blue,
    output logic [7:0]  frame_cnt
);

    localparam int BAR_W  = H_PIXEL / NUM_BARS;
    localparam int BAND_H = V_PIXEL / NUM_BANDS;

    logic [CW-1:0] x_reg, y_reg, bar_pos_reg, band_pos_reg;
    logic [2:0]    bar_idx_reg;    // only the index mod 8 selects a colour
    logic [2:0]    band_idx_reg;   // kept modulo 5: the band colour index
    logic [2:0]    mode_q_reg;
    logic [7:0]    frame_cnt_reg;
    logic [23:0]   rgb_reg;

    // Position of the pixel being processed this cycle. A vsync cycle is
    // treated as position (0,0) of the new frame so a coincident de pixel is
    // rendered there with the freshly captured mode and frame count.
    logic [CW-1:0] x_cur, y_cur, bar_pos_cur, band_pos_cur;
    logic [2:0]    bar_idx_cur, band_idx_cur, mode_cur;
    logic [7:0]    frame_cur;

    logic [CW-1:0] x_next, y_next, bar_pos_next, band_pos_next;
    logic [2:0]    bar_idx_next, band_idx_next;
    logic          line_end, frame_end;

    logic [CW-1:0] x_scroll;
    logic          chk_static, chk_scroll, grey_sat;
    logic [7:0]    grey;
    logic [23:0]   pix_next;

    always_comb begin
        x_cur        = vsync ? '0 : x_reg;
        y_cur        = vsync ? '0 : y_reg;
        bar_pos_cur  = vsync ? '0 : bar_pos_reg;
        bar_idx_cur  = vsync ? '0 : bar_idx_reg;
        band_pos_cur = vsync ? '0 : band_pos_reg;
        band_idx_cur = vsync ? '0 : band_idx_reg;
        mode_cur     = vsync ? mode : mode_q_reg;
        frame_cur    = vsync ? frame_cnt_reg + 8'd1 : frame_cnt_reg;

        line_end  = (x_cur == CW'(H_PIXEL - 1));
        frame_end = line_end && (y_cur == CW'(V_PIXEL - 1));

        x_next        = x_cur;
        y_next        = y_cur;
        bar_pos_next  = bar_pos_cur;
        bar_idx_next  = bar_idx_cur;
        band_pos_next = band_pos_cur;
        band_idx_next = band_idx_cur;

        if (de) begin
            if (line_end) begin
                x_next       = '0;
                bar_pos_next = '0;
                bar_idx_next = '0;
                if (frame_end) begin
                    y_next        = '0;
                    band_pos_next = '0;
                    band_idx_next = '0;
                end else begin
                    y_next = y_cur + CW'(1);
                    if (band_pos_cur == CW'(BAND_H - 1)) begin
                        band_pos_next = '0;
                        band_idx_next = (band_idx_cur == 3'd4) ? 3'd0 : band_idx_cur + 3'd1;
                    end else begin
                        band_pos_next = band_pos_cur + CW'(1);
                    end
                end
            end else begin
                x_next = x_cur + CW'(1);
                if (bar_pos_cur == CW'(BAR_W - 1)) begin
                    bar_pos_next = '0;
                    bar_idx_next = bar_idx_cur + 3'd1;
                end else begin
                    bar_pos_next = bar_pos_cur + CW'(1);
                end
            end
        end
    end

    // Pattern colour for the current pixel.
    always_comb begin
        x_scroll   = x_cur + CW'({frame_cur, 2'b00});
        chk_static = x_cur[CHECK_LOG2] ^ y_cur[CHECK_LOG2];
        chk_scroll = x_scroll[CHECK_LOG2] ^ y_cur[CHECK_LOG2];
        grey_sat   = (32'(x_cur) >= 32'd2048);
        grey       = grey_sat ? 8'hFF : x_cur[10:3];
        pix_next   = 24'h000000;

        case (mode_cur)
            3'd0: pix_next = solid_rgb;
            3'd1: begin
                case (bar_idx_cur)
                    3'd0:    pix_next = 24'hFFFFFF;
                    3'd1:    pix_next = 24'hFFFF00;
                    3'd2:    pix_next = 24'h00FFFF;
                    3'd3:    pix_next = 24'h00FF00;
                    3'd4:    pix_next = 24'hFF00FF;
                    3'd5:    pix_next = 24'hFF0000;
                    3'd6:    pix_next = 24'h0000FF;
                    default: pix_next = 24'h000000;
                endcase
            end
            3'd2: begin
                case (band_idx_cur)
                    3'd1:    pix_next = 24'hFFFFFF;
                    3'd2:    pix_next = 24'hFF0000;
                    3'd3:    pix_next = 24'h00FF00;
                    3'd4:    pix_next = 24'h0000FF;
                    default: pix_next = 24'h000000;
                endcase
            end
            3'd3:    pix_next = chk_static ? 24'hFFFFFF : 24'h000000;
            3'd4:    pix_next = {grey, grey, grey};
            3'd5:    pix_next = chk_scroll ? 24'hFFFFFF : 24'h000000;
            default: pix_next = 24'h000000;
        endcase
    end

    always_ff @(posedge pixclk) begin
        if (reset) begin
            x_reg         <= '0;
            y_reg         <= '0;
            bar_pos_reg   <= '0;
            bar_idx_reg   <= '0;
            band_pos_reg  <= '0;
            band_idx_reg  <= '0;
            mode_q_reg    <= '0;
            frame_cnt_reg <= '0;
            rgb_reg       <= '0;
        end else begin
            x_reg         <= x_next;
            y_reg         <= y_next;
            bar_pos_reg   <= bar_pos_next;
            bar_idx_reg   <= bar_idx_next;
            band_pos_reg  <= band_pos_next;
            band_idx_reg  <= band_idx_next;
            mode_q_reg    <= mode_cur;
            frame_cnt_reg <= frame_cur;
            rgb_reg       <= de ? pix_next : 24'h000000;
        end
    end

    assign red       = rgb_reg[23:16];
    assign green     = rgb_reg[15:8];
    assign blue      = rgb_reg[7:0];
    assign frame_cnt = frame_cnt_reg;

endmodule

// File: doc/test_pattern_gen.md
TEST_PATTERN_GEN -- requirements
Module: test_pattern_gen

Interface
REQ-001 SHALL have parameter H_PIXEL, default 1280, active pixels per line.
REQ-002 SHALL have parameter V_PIXEL, default 720, active lines per frame.
REQ-003 SHALL have parameter NUM_BARS, default 8, vertical colour bars per line; BAR_W = H_PIXEL/NUM_BARS, integer, at least 1.
REQ-004 SHALL have parameter NUM_BANDS, default 5, horizontal bands per frame; BAND_H = V_PIXEL/NUM_BANDS, integer, at least 1.
REQ-005 SHALL have parameter CHECK_LOG2, default 5, checker square edge = 2^CHECK_LOG2 pixels.
REQ-006 SHALL have parameter CW, default 12, width of the x/y counters.
REQ-007 SHALL have port pixclk, input, 1 bit: pixel clock; all logic on the rising edge.
REQ-008 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-009 SHALL have port de, input, 1 bit: active-video pixel strobe.
REQ-010 SHALL have port vsync, input, 1 bit: one-cycle frame-start pulse.
REQ-011 SHALL have port mode, input, 3 bits: pattern select, sampled only at frame start.
REQ-012 SHALL have port solid_rgb, input, 24 bits: solid colour, ordered {R,G,B}.
REQ-013 SHALL have ports red, green and blue, outputs, 8 bits each: registered pixel colour.
REQ-014 SHALL have port frame_cnt, output, 8 bits: frames started since reset, wraps at 255.

Function
REQ-015 SHALL keep internal counters x, y (CW bits), bar_pos, bar_idx, band_pos, band_idx and mode_q.
REQ-016 On vsync: x, y, bar_pos, bar_idx, band_pos and band_idx SHALL clear to 0; mode_q SHALL load mode; frame_cnt SHALL increment modulo 256.
REQ-017 Each de cycle SHALL increment x; at x = H_PIXEL-1, x SHALL wrap to 0 and y SHALL increment.
REQ-018 At y = V_PIXEL-1 with line end, y SHALL wrap to 0 without vsync.
REQ-019 bar_pos SHALL increment per de cycle; at BAR_W-1 it SHALL clear and bar_idx SHALL increment; both SHALL clear at line end.
REQ-020 band_pos and band_idx SHALL follow the same scheme per line, using BAND_H, and both SHALL clear on y wrap.
REQ-021 The design SHALL contain no divider or multiplier; bar and band selection SHALL use only the counters.
REQ-022 If vsync and de coincide, the vsync pixel SHALL be rendered as (0,0) using the new mode; counters SHALL then hold x=1.
REQ-023 Outputs SHALL be registered with exactly 1-cycle latency: the colour for a de pixel appears on the next edge.
REQ-024 In any cycle following de=0, outputs SHALL be 0,0,0.
REQ-025 mode_q 0 SHALL output solid_rgb.
REQ-026 mode_q 1 SHALL output colour bars from bar_idx mod 8: white, yellow, cyan, green, magenta, red, blue, black (components 0 or 255).
REQ-027 mode_q 2 SHALL output bands from band_idx: black, white, red, green, blue, repeating mod 5.
REQ-028 mode_q 3 SHALL output white when x[CHECK_LOG2] XOR y[CHECK_LOG2] is 1, else black.
REQ-029 mode_q 4 SHALL output grey R=G=B=x[10:3], saturated to 255 when x >= 2048.
REQ-030 mode_q 5 SHALL output the mode-3 checkerboard with x replaced by (x + 4*frame_cnt) mod 2^CW.
REQ-031 mode_q 6 and 7 SHALL output black.
REQ-032 A mode change between vsync pulses SHALL have no effect until the next vsync.

Reset
REQ-033 While reset=1, all counters, mode_q, frame_cnt, red, green and blue SHALL be 0 on each edge; reset SHALL override vsync and de.
REQ-034 Reset mid-frame SHALL restart rendering at (0,0), mode 0, on the first de after release.

Verification
REQ-035 Reset, vsync with mode=0, solid_rgb=0x123456, de held 3 cycles -> outputs 0x12,0x34,0x56 from the cycle after the first de, and 0 one cycle after de falls.
REQ-036 Mode 1, one full 1280-pixel line -> 160 white pixels, then yellow (255,255,0), and so on; pixel 1279 is black; the next line starts white.
REQ-037 Mode 2, a full 720-line frame -> line 0 black, line 144 white, line 576 blue; line 719 blue; y wraps to 0.
REQ-038 Mode 3 -> pixel (31,0) white=0, pixel (32,0) = 255, pixel (32,32) = 0; mode changed to 4 mid-frame -> pattern unchanged until the next vsync.
REQ-039 vsync and de in the same cycle with mode=4 -> output (0,0,0) for x=0; the next pixel gives grey 0; pixel x=8 gives grey 1.
REQ-040 256 vsync pulses -> frame_cnt returns to 0; mode 5, frame_cnt=8 -> pixel (0,0) white.
